decoder_nto2n_scan: RTL and testbench

- Parametrised, registered successor to the 3-to-8 decoder: SEL_W-bit select in, one-hot 2**SEL_W-bit output out.
- Adds a valid/ready load handshake, a global enable, and an auto-scan mode.
- In auto-scan mode an internal counter walks the active output line with a programmable dwell time (digit/row strobing).
- Sits between control logic and multiplexed display/row-select drivers.

---
 rtl/decoder_nto2n_scan_if.sv | 26 ++
 rtl/decoder_nto2n_scan.sv | 83 ++++++++
 tb/tb_decoder_nto2n_scan.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/decoder_nto2n_scan_if.sv
// Bundle for the decoder's load handshake and decoded outputs.
// Handshake: a load happens on a rising clk edge where in_valid && in_ready. in_ready simply mirrors en.
interface decoder_nto2n_scan_if #(
  parameter int SEL_W = 3
);
  localparam int OUT_W = 2**SEL_W;

  logic             en;
  logic             mode;
  logic             in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] sel;
  logic [OUT_W-1:0] out;
  logic [SEL_W-1:0] idx;
  logic             wrap;

  modport master (
    output en, mode, in_valid, sel,
    input  in_ready, out, idx, wrap
  );

  modport slave (
    input  en, mode, in_valid, sel,
    output in_ready, out, idx, wrap
  );
endinterface

// File: rtl/decoder_nto2n_scan.sv
// Registered N-to-2^N decoder with a load handshake, global enable and auto-scan mode.
// Define DECODER_ACTIVE_LOW_EN for one-cold outputs (all ones when idle or in reset).
module decoder_nto2n_scan #(
  parameter int SEL_W = 3,
  parameter int DWELL = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  decoder_nto2n_scan_if.slave  bus,
  output logic [1:0]           o_dbg_state
);
  localparam int OUT_W = 2**SEL_W;
  localparam int CNT_W = ($clog2(DWELL + 1) < 1) ? 1 : $clog2(DWELL + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
`ifdef DECODER_ACTIVE_LOW_EN
  localparam logic OUT_INV = 1'b1;
`else
  localparam logic OUT_INV = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_SCAN = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [SEL_W-1:0] r_idx, w_idx_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_wrap, w_wrap_nxt;
  logic [OUT_W-1:0] r_out, w_out_nxt;
  logic             w_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_wrap  <= 1'b0;
      r_out   <= {OUT_W{OUT_INV}};
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_wrap  <= w_wrap_nxt;
      r_out   <= w_out_nxt;
    end
  end

  // Enable dominates; a load beats the dwell terminal count.
  always_comb begin
    w_load      = bus.in_valid && bus.en;
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_wrap_nxt  = 1'b0;
    if (!bus.en) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else if (w_load) begin
      w_state_nxt = bus.mode ? ST_SCAN : ST_HOLD;
      w_idx_nxt   = bus.sel;
      w_cnt_nxt   = '0;
    end else if (r_state == ST_SCAN) begin
      if (r_cnt == CNT_LAST) begin
        w_cnt_nxt  = '0;
        w_idx_nxt  = r_idx + 1'b1;
        w_wrap_nxt = (r_idx == {SEL_W{1'b1}});
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
    // Output is decoded from the next index so it is purely registered.
    w_out_nxt = (w_state_nxt == ST_IDLE) ? '0 : (OUT_W'(1) << w_idx_nxt);
    w_out_nxt = w_out_nxt ^ {OUT_W{OUT_INV}};
  end

  assign bus.in_ready = bus.en;
  assign bus.out      = r_out;
  assign bus.idx      = r_idx;
  assign bus.wrap     = r_wrap;
  assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_decoder_nto2n_scan.sv
// Bench for decoder_nto2n_scan: directed scenarios then random traffic against a cycle-age reference model.
module tb_decoder_nto2n_scan;
  localparam int SEL_W = 3;
  localparam int DWELL = 2;
  localparam int OUT_W = 2**SEL_W;
`ifdef DECODER_ACTIVE_LOW_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  decoder_nto2n_scan_if #(.SEL_W(SEL_W)) bus();
  logic [1:0] dbg_state;

  decoder_nto2n_scan #(.SEL_W(SEL_W), .DWELL(DWELL)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .o_dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_pass = 0;

  // driven input copies
  logic             drv_en = 1'b0, drv_valid = 1'b0, drv_mode = 1'b0;
  logic [SEL_W-1:0] drv_sel = '0;

  // reference model: mode 0 idle, 1 hold, 2 scan; scan index is base + age/DWELL
  int               m_state = 0;
  int               m_base = 0;
  int               m_age = 0;
  logic [SEL_W-1:0] m_idx = '0;
  logic             m_wrap = 1'b0;
  logic [OUT_W-1:0] exp_q[$];

  function automatic logic [OUT_W-1:0] pol(input logic [OUT_W-1:0] v);
    return v ^ {OUT_W{INV}};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive(input logic en, input logic valid, input logic mode, input logic [SEL_W-1:0] sel);
    drv_en = en; drv_valid = valid; drv_mode = mode; drv_sel = sel;
    bus.en = en; bus.in_valid = valid; bus.mode = mode; bus.sel = sel;
  endtask

  task automatic model_update();
    if (!drv_en) begin
      m_state = 0;
      m_wrap  = 1'b0;
    end else if (drv_valid) begin
      m_state = drv_mode ? 2 : 1;
      m_base  = int'(drv_sel);
      m_age   = 0;
      m_idx   = drv_sel;
      m_wrap  = 1'b0;
    end else if (m_state == 2) begin
      m_age++;
      m_idx  = SEL_W'((m_base + m_age / DWELL) % OUT_W);
      m_wrap = (m_age % DWELL == 0) && (m_idx == '0);
    end else begin
      m_wrap = 1'b0;
    end
    exp_q.push_back(pol((m_state == 0) ? '0 : (OUT_W'(1) << m_idx)));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check("out", bus.out, exp_q.pop_front());
    check("idx", bus.idx, m_idx);
    check("wrap", bus.wrap, m_wrap);
    check("in_ready", bus.in_ready, drv_en);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_out", bus.out, pol('0));
    check("rst_idx", bus.idx, 0);
    check("rst_wrap", bus.wrap, 0);
    m_state = 0; m_idx = '0; m_wrap = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : stim
    int wraps;
    logic [SEL_W-1:0] saved_idx;
    logic [SEL_W-1:0] seq[6];
    logic [SEL_W-1:0] exp_seq[6];
    exp_seq = '{3'd6, 3'd6, 3'd7, 3'd7, 3'd0, 3'd0};

    drive(1'b0, 1'b0, 1'b0, '0);
    #2;
    check("reset_out", bus.out, pol('0));
    check("reset_idx", bus.idx, 0);
    check("reset_wrap", bus.wrap, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // direct load and hold
    drive(1'b1, 1'b1, 1'b0, 3'd5);
    step();
    check("load5_out", bus.out, pol(8'b0010_0000));
    check("load5_idx", bus.idx, 5);
    drive(1'b1, 1'b0, 1'b0, 3'd0);
    repeat (20) step();

    // truth-table sweep
    for (int s = 0; s < OUT_W; s++) begin
      drive(1'b1, 1'b1, 1'b0, SEL_W'(s));
      step();
      check("sweep", bus.out, pol(OUT_W'(1) << s));
    end

    // scan from 6
    drive(1'b1, 1'b1, 1'b1, 3'd6);
    step();
    seq[0] = bus.idx;
    drive(1'b1, 1'b0, 1'b0, 3'd0);
    wraps = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k < 6) seq[k] = bus.idx;
      if (bus.wrap) wraps++;
    end
    for (int k = 0; k < 6; k++) check("scan_seq", seq[k], exp_seq[k]);
    check("scan_wraps", wraps, 3);

    // enable drop mid-scan
    saved_idx = m_idx;
    drive(1'b0, 1'b0, 1'b1, 3'd0);
    step();
    check("en_off_out", bus.out, pol('0));
    check("en_off_idx", bus.idx, saved_idx);
    drive(1'b1, 1'b0, 1'b1, 3'd0);
    repeat (3) step();
    check("en_on_idle", bus.out, pol('0));

    // load on the dwell terminal count with idx=7
    drive(1'b1, 1'b1, 1'b1, 3'd7);
    step();
    drive(1'b1, 1'b0, 1'b0, 3'd0);
    step();
    drive(1'b1, 1'b1, 1'b0, 3'd2);
    step();
    check("tc_load_idx", bus.idx, 2);
    check("tc_load_out", bus.out, pol(8'b0000_0100));
    check("tc_load_wrap", bus.wrap, 0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 5) == 0,
            1'($urandom_range(0, 1)), SEL_W'($urandom_range(0, OUT_W - 1)));
      step();
    end

    // async reset mid-scan
    drive(1'b1, 1'b1, 1'b1, 3'd3);
    step();
    drive(1'b1, 1'b0, 1'b0, 3'd0);
    repeat (3) step();
    async_reset();
    step();
    check("post_rst_idle", bus.out, pol('0));
    for (int n = 0; n < 50; n++) begin
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
            1'($urandom_range(0, 1)), SEL_W'($urandom_range(0, OUT_W - 1)));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
